// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU dispatcher and the external ALU:
// opcode encodings, dispatcher state enum and an opcode legality helper.
// The HALT state only exists when ALU_DISPATCH_TRAP_EN is defined.
package cpu_pkg;

    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h08;
    localparam logic [7:0] OP_AND = 8'h0A;
    localparam logic [7:0] OP_XOR = 8'h0C;

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_REG,
        FETCH_IMM,
        EXEC
`ifdef ALU_DISPATCH_TRAP_EN
        , HALT
`endif
    } state_e;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == OP_SUB) || (op == OP_ADD) || (op == OP_OR) ||
               (op == OP_AND) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x 8-bit architectural register file: one synchronous write port,
// two combinational read ports (execute operand and debug read).
// All registers clear on asynchronous active-low reset.
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [IW-1:0] raddr_a_i,
    output logic [7:0]    rdata_a_o,
    input  logic [IW-1:0] raddr_b_i,
    output logic [7:0]    rdata_b_o
);

    logic [7:0] regs_q [NREGS];

    // Register storage: clear on reset, single write port otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-edge value, so a write in progress is not forwarded.
    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_dispatch.sv
// Byte-stream instruction dispatcher for an external combinational ALU.
// Instructions are opcode, register index, immediate; EXEC drives the ALU
// and writes its result back into the indexed register.
// Optional feature: define ALU_DISPATCH_TRAP_EN to make illegal
// instructions sticky and halt dispatch until reset.
module alu_dispatch
    import cpu_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic [7:0]               alu_opcode,
    output logic [7:0]               alu_operand_0,
    output logic [7:0]               alu_operand_1,
    input  logic [7:0]               alu_result,
    output logic                     done,
    input  logic [$clog2(NREGS)-1:0] rd_idx,
    output logic [7:0]               rd_data,
    output logic                     illegal
);

    localparam int         IW      = $clog2(NREGS);
    localparam logic [8:0] NREGS_B = 9'(NREGS);

    state_e     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] imm_q, imm_d;

    logic       accept;
    logic       in_exec;
    logic       exec_legal;
    logic [7:0] exec_operand;

    assign accept     = in_valid && in_ready;
    assign in_exec    = (state_q == EXEC);
    // Index is checked on the full byte so out-of-range values never alias.
    assign exec_legal = is_legal_op(opcode_q) && ({1'b0, idx_q} < NREGS_B);

    alu_regfile #(
        .NREGS (NREGS),
        .IW    (IW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (done),
        .waddr_i   (idx_q[IW-1:0]),
        .wdata_i   (alu_result),
        .raddr_a_i (idx_q[IW-1:0]),
        .rdata_a_o (exec_operand),
        .raddr_b_i (rd_idx),
        .rdata_b_o (rd_data)
    );

    // State and latched instruction fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH_OP;
            opcode_q <= 8'h00;
            idx_q    <= 8'h00;
            imm_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            idx_q    <= idx_d;
            imm_q    <= imm_d;
        end
    end

    // Next-state: advance on each accepted byte, EXEC lasts one cycle.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        idx_d    = idx_q;
        imm_d    = imm_q;
        case (state_q)
            FETCH_OP: begin
                if (accept) begin
                    opcode_d = in_data;
                    state_d  = FETCH_REG;
                end
            end
            FETCH_REG: begin
                if (accept) begin
                    idx_d   = in_data;
                    state_d = FETCH_IMM;
                end
            end
            FETCH_IMM: begin
                if (accept) begin
                    imm_d   = in_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
`ifdef ALU_DISPATCH_TRAP_EN
                state_d = exec_legal ? FETCH_OP : HALT;
`else
                state_d = FETCH_OP;
`endif
            end
`ifdef ALU_DISPATCH_TRAP_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = FETCH_OP;
            end
        endcase
    end

    // Outputs: ALU bus is idle (zero) outside EXEC; done/illegal decode EXEC.
    always_comb begin
        in_ready      = (state_q == FETCH_OP) || (state_q == FETCH_REG) ||
                        (state_q == FETCH_IMM);
        alu_opcode    = 8'h00;
        alu_operand_0 = 8'h00;
        alu_operand_1 = 8'h00;
        if (in_exec) begin
            alu_opcode    = opcode_q;
            alu_operand_0 = exec_operand;
            alu_operand_1 = imm_q;
        end
        done = in_exec && exec_legal;
`ifdef ALU_DISPATCH_TRAP_EN
        illegal = (in_exec && !exec_legal) || (state_q == HALT);
`else
        illegal = in_exec && !exec_legal;
`endif
    end

endmodule
